// File: rtl/dm_arb_if.sv
// rtl/dm_arb_if.sv - single-word request port between a dm requester and dm_arb
interface dm_arb_if #(
  parameter int AW = 7,
  parameter int DW = 32
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ack;
  logic [DW-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/dm_arb.sv
// rtl/dm_arb.sv - two-port arbiter/sequencer issuing one-cycle strobes to the data memory
module dm_arb #(
  parameter int AW        = 7,
  parameter int DW        = 32,
  parameter int RD_LAT    = 1,
  parameter int FIXED_PRI = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  dm_arb_if.slave       p0,
  dm_arb_if.slave       p1,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_wdata,
  output logic          dm_rd,
  output logic          dm_wr,
  input  logic [DW-1:0] dm_rdata
);

  typedef enum logic [1:0] {IDLE, CMD, WAIT, DONE} state_t;

  localparam logic [1:0] CNT_INIT = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

  state_t        state_q, state_d;
  logic [AW-1:0] dm_addr_q, dm_addr_d;
  logic [DW-1:0] dm_wdata_q, dm_wdata_d;
  logic          dm_rd_q, dm_rd_d;
  logic          dm_wr_q, dm_wr_d;
  logic          p0_ack_q, p0_ack_d;
  logic          p1_ack_q, p1_ack_d;
  logic [DW-1:0] p0_rdata_q, p0_rdata_d;
  logic [DW-1:0] p1_rdata_q, p1_rdata_d;
  logic          last_grant_q, last_grant_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic [1:0]    cnt_q, cnt_d;

  logic          sel1;
  logic          finish;

  // On a tie, port 1 wins only in round-robin mode when port 0 was granted last.
  assign sel1 = p1.req & (~p0.req | ((FIXED_PRI == 0) & ~last_grant_q));

  always_comb begin
    state_d      = state_q;
    dm_addr_d    = dm_addr_q;
    dm_wdata_d   = dm_wdata_q;
    dm_rd_d      = 1'b0;
    dm_wr_d      = 1'b0;
    p0_ack_d     = 1'b0;
    p1_ack_d     = 1'b0;
    p0_rdata_d   = p0_rdata_q;
    p1_rdata_d   = p1_rdata_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    we_d         = we_q;
    cnt_d        = cnt_q;
    finish       = 1'b0;

    case (state_q)
      IDLE: begin
        if (p0.req | p1.req) begin
          owner_d      = sel1;
          last_grant_d = sel1;
          we_d         = sel1 ? p1.we    : p0.we;
          dm_addr_d    = sel1 ? p1.addr  : p0.addr;
          dm_wdata_d   = sel1 ? p1.wdata : p0.wdata;
          dm_wr_d      = we_d;
          dm_rd_d      = ~we_d;
          state_d      = CMD;
        end
      end
      CMD: begin
        if (we_q || (RD_LAT == 0)) begin
          finish = 1'b1;
        end else begin
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          finish = 1'b1;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (finish) begin
      state_d = DONE;
      if (owner_q) begin
        p1_ack_d = 1'b1;
        if (!we_q) p1_rdata_d = dm_rdata;
      end else begin
        p0_ack_d = 1'b1;
        if (!we_q) p0_rdata_d = dm_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      dm_addr_q    <= '0;
      dm_wdata_q   <= '0;
      dm_rd_q      <= 1'b0;
      dm_wr_q      <= 1'b0;
      p0_ack_q     <= 1'b0;
      p1_ack_q     <= 1'b0;
      p0_rdata_q   <= '0;
      p1_rdata_q   <= '0;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      cnt_q        <= 2'd0;
    end else begin
      state_q      <= state_d;
      dm_addr_q    <= dm_addr_d;
      dm_wdata_q   <= dm_wdata_d;
      dm_rd_q      <= dm_rd_d;
      dm_wr_q      <= dm_wr_d;
      p0_ack_q     <= p0_ack_d;
      p1_ack_q     <= p1_ack_d;
      p0_rdata_q   <= p0_rdata_d;
      p1_rdata_q   <= p1_rdata_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
    end
  end

  assign dm_addr  = dm_addr_q;
  assign dm_wdata = dm_wdata_q;
  assign dm_rd    = dm_rd_q;
  assign dm_wr    = dm_wr_q;
  assign p0.ack   = p0_ack_q;
  assign p1.ack   = p1_ack_q;
  assign p0.rdata = p0_rdata_q;
  assign p1.rdata = p1_rdata_q;

endmodule

// File: tb/tb_dm_arb.sv
// tb/tb_dm_arb.sv - directed bench for dm_arb in round-robin and fixed-priority builds
module tb_dm_arb;
  localparam int AW = 7;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dm_arb_if #(.AW(AW), .DW(DW)) a0 ();
  dm_arb_if #(.AW(AW), .DW(DW)) a1 ();
  dm_arb_if #(.AW(AW), .DW(DW)) b0 ();
  dm_arb_if #(.AW(AW), .DW(DW)) b1 ();

  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, a_rdata, b_wdata, b_rdata;
  logic          a_rd, a_wr, b_rd, b_wr;

  dm_arb #(.AW(AW), .DW(DW), .RD_LAT(1), .FIXED_PRI(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .p0(a0), .p1(a1),
    .dm_addr(a_addr), .dm_wdata(a_wdata), .dm_rd(a_rd), .dm_wr(a_wr), .dm_rdata(a_rdata)
  );

  dm_arb #(.AW(AW), .DW(DW), .RD_LAT(1), .FIXED_PRI(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .p0(b0), .p1(b1),
    .dm_addr(b_addr), .dm_wdata(b_wdata), .dm_rd(b_rd), .dm_wr(b_wr), .dm_rdata(b_rdata)
  );

  // Data memories with one cycle of read latency
  logic [DW-1:0] mem_a [0:127];
  logic [DW-1:0] mem_b [0:127];
  always @(posedge clk) begin
    if (a_wr) mem_a[a_addr] <= a_wdata;
    if (a_rd) a_rdata <= mem_a[a_addr];
    if (b_wr) mem_b[b_addr] <= b_wdata;
    if (b_rd) b_rdata <= mem_b[b_addr];
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input logic req, input logic we,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    if (p == 0) begin
      a0.req = req; a0.we = we; a0.addr = addr; a0.wdata = wd;
    end else begin
      a1.req = req; a1.we = we; a1.addr = addr; a1.wdata = wd;
    end
  endtask

  task automatic xfer(input int p, input logic we, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd, input string tag);
    int edges = 0;
    int nrd = 0;
    int nwr = 0;
    int other = 0;
    logic ack = 1'b0;
    logic [DW-1:0] rd = '0;
    logic [AW-1:0] seen_addr = '0;
    drive(p, 1'b1, we, addr, wd);
    while (!ack && edges < 10) begin
      @(negedge clk);
      edges++;
      nrd += int'(a_rd);
      nwr += int'(a_wr);
      if (a_rd | a_wr) seen_addr = a_addr;
      other += int'((p == 0) ? a1.ack : a0.ack);
      ack = (p == 0) ? a0.ack : a1.ack;
      rd  = (p == 0) ? a0.rdata : a1.rdata;
    end
    drive(p, 1'b0, 1'b0, '0, '0);
    chk({tag, "_latency"}, edges, we ? 32'd2 : 32'd3);
    chk({tag, "_rd_strobes"}, nrd, we ? 32'd0 : 32'd1);
    chk({tag, "_wr_strobes"}, nwr, we ? 32'd1 : 32'd0);
    chk({tag, "_addr"}, 32'(seen_addr), 32'(addr));
    chk({tag, "_other_ack"}, other, 32'd0);
    if (!we) chk({tag, "_rdata"}, rd, exp_rd);
    @(negedge clk);
  endtask

  int order [4];
  logic [DW-1:0] rdv [4];
  int k;
  int dual;
  int cyc;
  int b0_acks;
  int b1_acks;
  logic got;

  initial begin
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    b0.req = 1'b0; b0.we = 1'b0; b0.addr = 7'd1; b0.wdata = '0;
    b1.req = 1'b0; b1.we = 1'b0; b1.addr = 7'd2; b1.wdata = '0;

    #12;
    chk("rst_dm_rd", 32'(a_rd), 32'd0);
    chk("rst_dm_wr", 32'(a_wr), 32'd0);
    chk("rst_dm_addr", 32'(a_addr), 32'd0);
    chk("rst_dm_wdata", a_wdata, 32'd0);
    chk("rst_acks", {30'd0, a1.ack, a0.ack}, 32'd0);
    chk("rst_rdata", a0.rdata | a1.rdata, 32'd0);

    // Async reset while a write strobe is up
    @(negedge clk) rst_n = 1'b1;
    drive(0, 1'b1, 1'b1, 7'd5, 32'd9);
    @(negedge clk);
    chk("cmd_wr_up", 32'(a_wr), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_wr_drop", 32'(a_wr), 32'd0);
    chk("async_addr_clr", 32'(a_addr), 32'd0);
    chk("async_wdata_clr", a_wdata, 32'd0);
    drive(0, 1'b0, 1'b0, '0, '0);

    // Async reset while a read strobe is up
    @(negedge clk) rst_n = 1'b1;
    drive(1, 1'b1, 1'b0, 7'd3, '0);
    @(negedge clk);
    chk("cmd_rd_up", 32'(a_rd), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rd_drop", 32'(a_rd), 32'd0);
    chk("async_ack_low", {30'd0, a1.ack, a0.ack}, 32'd0);
    drive(1, 1'b0, 1'b0, '0, '0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);

    xfer(0, 1'b1, 7'd0,   32'd6,   '0,       "p0_wr0");
    xfer(0, 1'b0, 7'd0,   '0,      32'd6,    "p0_rd0");
    xfer(0, 1'b1, 7'd4,   32'd12,  '0,       "p0_wr4");
    xfer(1, 1'b1, 7'd127, 32'd128, '0,       "p1_wr127");
    xfer(1, 1'b0, 7'd127, '0,      32'd128,  "p1_rd127");

    // Both ports reading back-to-back: grants must alternate, starting with port 0
    k = 0;
    dual = 0;
    cyc = 0;
    drive(0, 1'b1, 1'b0, 7'd4, '0);
    drive(1, 1'b1, 1'b0, 7'd0, '0);
    while (k < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (a0.ack && a1.ack) dual++;
      if (a0.ack) begin order[k] = 0; rdv[k] = a0.rdata; k++; end
      else if (a1.ack) begin order[k] = 1; rdv[k] = a1.rdata; k++; end
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    chk("rr_ack_count", k, 32'd4);
    chk("rr_dual_ack", dual, 32'd0);
    for (int i = 0; i < k; i++) begin
      chk($sformatf("rr_owner_%0d", i), order[i], i % 2);
      chk($sformatf("rr_rdata_%0d", i), rdv[i], (i % 2 == 1) ? 32'd6 : 32'd12);
    end
    @(negedge clk);

    // Address changed mid-transaction must not disturb the latched one
    drive(0, 1'b1, 1'b0, 7'd127, '0);
    @(negedge clk);
    chk("chg_cmd_addr", 32'(a_addr), 32'd127);
    chk("chg_cmd_rd", 32'(a_rd), 32'd1);
    a0.addr = 7'd0;
    @(negedge clk);
    chk("chg_wait_addr", 32'(a_addr), 32'd127);
    chk("chg_wait_rd", 32'(a_rd), 32'd0);
    @(negedge clk);
    chk("chg_ack", 32'(a0.ack), 32'd1);
    chk("chg_rdata", a0.rdata, 32'd128);
    drive(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("chg_ack_pulse", 32'(a0.ack), 32'd0);

    // Fixed priority: port 1 starves while port 0 keeps requesting
    b0_acks = 0;
    b1_acks = 0;
    b0.req = 1'b1;
    b1.req = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      b0_acks += int'(b0.ack);
      b1_acks += int'(b1.ack);
    end
    chk("fp_p1_starved", b1_acks, 32'd0);
    chk("fp_p0_acks", b0_acks, 32'd7);
    b0.req = 1'b0;
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 12) begin
      @(negedge clk);
      cyc++;
      got = b1.ack;
    end
    b1.req = 1'b0;
    chk("fp_p1_served", 32'(got), 32'd1);
    chk("fp_p1_wait", cyc, 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
